// File: rtl/tlc_signal_monitor.sv
// Independent safety checker for the traffic light controller lamp outputs.
// Latches the first sequencing/timing violation and requests red flashing until cleared.
//
// state   | meaning
// INIT    | one cycle: reload prev/dwell from the live inputs, no checks
// MONITOR | all rules evaluated every cycle, first violation is latched
// FAULT   | outputs frozen, prev/dwell keep tracking, wait for faultClear with both red
module tlc_signal_monitor #(
    parameter int unsigned MIN_GREEN_CYC  = 500_000_000,
    parameter int unsigned MIN_YELLOW_CYC = 300_000_000,
    parameter int unsigned MAX_YELLOW_CYC = 600_000_000,
    parameter int unsigned ALLRED_CYC     = 100_000_000
) (
    input  logic       Clk,
    input  logic       RstSync,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       faultClear,
    output logic       fault,
    output logic [2:0] faultCode,
    output logic       faultRoad,
    output logic       flashReq,
    output logic [1:0] monState
);

    typedef enum logic [1:0] {
        INIT    = 2'b00,
        MONITOR = 2'b01,
        FAULT   = 2'b10
    } mon_state_t;

    localparam logic [1:0] SIG_G = 2'b00;
    localparam logic [1:0] SIG_Y = 2'b01;
    localparam logic [1:0] SIG_R = 2'b10;
    localparam logic [1:0] SIG_X = 2'b11;

    localparam logic [30:0] MIN_GREEN  = MIN_GREEN_CYC[30:0];
    localparam logic [30:0] MIN_YELLOW = MIN_YELLOW_CYC[30:0];
    localparam logic [30:0] MAX_YELLOW = MAX_YELLOW_CYC[30:0];
    localparam logic [30:0] ALLRED     = ALLRED_CYC[30:0];
    localparam logic [30:0] DWELL_MAX  = '1;

    mon_state_t  state;
    logic [1:0]  prevHwy, prevFarm;
    logic [30:0] dwellHwy, dwellFarm;
    logic        firstHwy, firstFarm;

    logic [30:0] dwellHwyNxt, dwellFarmNxt;
    logic        firstHwyNxt, firstFarmNxt;
    logic [2:0]  hwyCode, farmCode, nextCode;
    logic        nextRoad, violation;

    // Lowest violation code for one road; the other road's red dwell gates R->G.
    function automatic logic [2:0] road_check(
        input logic [1:0]  sig,
        input logic [1:0]  prev,
        input logic [30:0] dwell,
        input logic        first,
        input logic [1:0]  oSig,
        input logic [1:0]  oPrev,
        input logic [30:0] oDwell
    );
        logic legal;
        logic oRedLong;
        legal = (prev == SIG_G && sig == SIG_Y) ||
                (prev == SIG_Y && sig == SIG_R) ||
                (prev == SIG_R && sig == SIG_G);
        oRedLong = (oSig == SIG_R) && (oPrev == SIG_R) && (oDwell >= ALLRED);
        road_check = 3'd0;
        if (sig == SIG_X) begin
            road_check = 3'd2;
        end else if (sig != prev) begin
            if (!legal)
                road_check = 3'd3;
            else if (prev == SIG_Y && !first && dwell < MIN_YELLOW)
                road_check = 3'd4;
            else if (prev == SIG_G && !first && dwell < MIN_GREEN)
                road_check = 3'd5;
            else if (prev == SIG_R && !oRedLong)
                road_check = 3'd7;
        end else if (sig == SIG_Y && dwell == MAX_YELLOW) begin
            road_check = 3'd6;
        end
    endfunction

    always_comb begin
        dwellHwyNxt  = 31'd1;
        dwellFarmNxt = 31'd1;
        if (highwaySignal == prevHwy)
            dwellHwyNxt = (dwellHwy == DWELL_MAX) ? dwellHwy : dwellHwy + 31'd1;
        if (farmSignal == prevFarm)
            dwellFarmNxt = (dwellFarm == DWELL_MAX) ? dwellFarm : dwellFarm + 31'd1;
        firstHwyNxt  = firstHwy && (highwaySignal == prevHwy);
        firstFarmNxt = firstFarm && (farmSignal == prevFarm);

        hwyCode  = road_check(highwaySignal, prevHwy, dwellHwy, firstHwy,
                              farmSignal, prevFarm, dwellFarm);
        farmCode = road_check(farmSignal, prevFarm, dwellFarm, firstFarm,
                              highwaySignal, prevHwy, dwellHwy);

        nextCode = 3'd0;
        nextRoad = 1'b0;
        if (highwaySignal != SIG_R && farmSignal != SIG_R) begin
            nextCode = 3'd1;
        end else if (hwyCode != 3'd0 && (farmCode == 3'd0 || hwyCode <= farmCode)) begin
            nextCode = hwyCode;
        end else if (farmCode != 3'd0) begin
            nextCode = farmCode;
            nextRoad = 1'b1;
        end
        violation = (nextCode != 3'd0);
    end

    always_ff @(posedge Clk or posedge RstSync) begin
        if (RstSync) begin
            state     <= INIT;
            prevHwy   <= SIG_R;
            prevFarm  <= SIG_R;
            dwellHwy  <= 31'd1;
            dwellFarm <= 31'd1;
            firstHwy  <= 1'b1;
            firstFarm <= 1'b1;
            fault     <= 1'b0;
            faultCode <= 3'd0;
            faultRoad <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    prevHwy   <= highwaySignal;
                    prevFarm  <= farmSignal;
                    dwellHwy  <= 31'd1;
                    dwellFarm <= 31'd1;
                    state     <= MONITOR;
                end
                MONITOR: begin
                    prevHwy   <= highwaySignal;
                    prevFarm  <= farmSignal;
                    dwellHwy  <= dwellHwyNxt;
                    dwellFarm <= dwellFarmNxt;
                    firstHwy  <= firstHwyNxt;
                    firstFarm <= firstFarmNxt;
                    if (violation) begin
                        state     <= FAULT;
                        fault     <= 1'b1;
                        faultCode <= nextCode;
                        faultRoad <= nextRoad;
                    end
                end
                FAULT: begin
                    prevHwy   <= highwaySignal;
                    prevFarm  <= farmSignal;
                    dwellHwy  <= dwellHwyNxt;
                    dwellFarm <= dwellFarmNxt;
                    firstHwy  <= firstHwyNxt;
                    firstFarm <= firstFarmNxt;
                    if (faultClear && highwaySignal == SIG_R && farmSignal == SIG_R) begin
                        state     <= INIT;
                        fault     <= 1'b0;
                        faultCode <= 3'd0;
                        faultRoad <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign flashReq = fault;
    assign monState = state;

endmodule

// File: tb/tb_tlc_signal_monitor.sv
// Directed and randomized bench for tlc_signal_monitor with shortened timing parameters.
// The reference model works on per-road colour/run-length arrays and the rule list.
module tb_tlc_signal_monitor;

    localparam int MIN_G  = 10;
    localparam int MIN_Y  = 4;
    localparam int MAX_Y  = 8;
    localparam int ALLRED = 2;
    localparam int G = 0, Y = 1, R = 2, X = 3;
    localparam int SAT = 2147483647;

    logic       Clk = 1'b0;
    logic       RstSync = 1'b1;
    logic [1:0] highwaySignal = 2'b10;
    logic [1:0] farmSignal = 2'b10;
    logic       faultClear = 1'b0;
    logic       fault;
    logic [2:0] faultCode;
    logic       faultRoad;
    logic       flashReq;
    logic [1:0] monState;

    tlc_signal_monitor #(
        .MIN_GREEN_CYC (MIN_G),
        .MIN_YELLOW_CYC(MIN_Y),
        .MAX_YELLOW_CYC(MAX_Y),
        .ALLRED_CYC    (ALLRED)
    ) dut (
        .Clk          (Clk),
        .RstSync      (RstSync),
        .highwaySignal(highwaySignal),
        .farmSignal   (farmSignal),
        .faultClear   (faultClear),
        .fault        (fault),
        .faultCode    (faultCode),
        .faultRoad    (faultRoad),
        .flashReq     (flashReq),
        .monState     (monState)
    );

    always #5 Clk = ~Clk;

    int nCompared = 0;
    int nMismatch = 0;

    // Reference model: mode 0 INIT, 1 MONITOR, 2 FAULT
    int mMode;
    int last[2];
    int held[2];
    bit fresh[2];
    int cur[2];
    bit mFault;
    int mCode;
    int mRoad;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mMode = 0;
        for (int r = 0; r < 2; r++) begin
            last[r]  = R;
            held[r]  = 1;
            fresh[r] = 1'b1;
        end
        mFault = 1'b0;
        mCode  = 0;
        mRoad  = 0;
    endtask

    function automatic int road_code(input int r);
        int o;
        int redFor;
        o = 1 - r;
        if (cur[r] == X) return 2;
        if (cur[r] != last[r]) begin
            if (last[r] == X || cur[r] != (last[r] + 1) % 3) return 3;
            if (last[r] == Y && held[r] < MIN_Y && !fresh[r]) return 4;
            if (last[r] == G && held[r] < MIN_G && !fresh[r]) return 5;
            if (cur[r] == G) begin
                redFor = (cur[o] == R && last[o] == R) ? held[o] : 0;
                if (redFor < ALLRED) return 7;
            end
        end else if (cur[r] == Y && held[r] == MAX_Y) begin
            return 6;
        end
        return 0;
    endfunction

    task automatic model_clock(input int h, input int f, input bit clr);
        int hc;
        int fc;
        cur[0] = h;
        cur[1] = f;
        if (mMode == 0) begin
            last[0] = h;
            last[1] = f;
            held[0] = 1;
            held[1] = 1;
            mMode = 1;
            return;
        end
        if (mMode == 1) begin
            hc = road_code(0);
            fc = road_code(1);
            if (h != R && f != R) begin
                mMode = 2; mFault = 1'b1; mCode = 1; mRoad = 0;
            end else if (hc != 0 && (fc == 0 || hc <= fc)) begin
                mMode = 2; mFault = 1'b1; mCode = hc; mRoad = 0;
            end else if (fc != 0) begin
                mMode = 2; mFault = 1'b1; mCode = fc; mRoad = 1;
            end
        end else if (clr && h == R && f == R) begin
            mMode = 0; mFault = 1'b0; mCode = 0; mRoad = 0;
        end
        for (int r = 0; r < 2; r++) begin
            if (cur[r] != last[r]) begin
                last[r]  = cur[r];
                held[r]  = 1;
                fresh[r] = 1'b0;
            end else if (held[r] < SAT) begin
                held[r]++;
            end
        end
    endtask

    task automatic compare_all();
        chk("fault",     {3'b0, fault},     {3'b0, mFault});
        chk("faultCode", {1'b0, faultCode}, mCode[3:0]);
        chk("faultRoad", {3'b0, faultRoad}, mRoad[3:0]);
        chk("flashReq",  {3'b0, flashReq},  {3'b0, mFault});
        chk("monState",  {2'b0, monState},  mMode[3:0]);
    endtask

    task automatic step(input int h, input int f, input bit clr = 1'b0);
        highwaySignal = h[1:0];
        farmSignal    = f[1:0];
        faultClear    = clr;
        @(posedge Clk);
        model_clock(h, f, clr);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic hold(input int h, input int f, input int n);
        for (int i = 0; i < n; i++) step(h, f);
    endtask

    // Asynchronous reset pulse mid-cycle, outputs checked before any clock edge.
    task automatic reset_pulse();
        #1 RstSync = 1'b1;
        #1;
        chk("async_fault",    {3'b0, fault},     4'd0);
        chk("async_code",     {1'b0, faultCode}, 4'd0);
        chk("async_road",     {3'b0, faultRoad}, 4'd0);
        chk("async_flash",    {3'b0, flashReq},  4'd0);
        chk("async_monState", {2'b0, monState},  4'd0);
        model_reset();
        #1 RstSync = 1'b0;
    endtask

    initial begin
        int hv;
        int fv;
        model_reset();
        repeat (2) @(negedge Clk);
        compare_all();
        chk("rst_monState", {2'b0, monState}, 4'd0);
        RstSync = 1'b0;

        // 1: legal cycling, three full rounds
        for (int rep = 0; rep < 3; rep++) begin
            hold(G, R, 12);
            hold(Y, R, 5);
            hold(R, R, 3);
            hold(R, G, 12);
            hold(R, Y, 5);
            hold(R, R, 3);
        end
        chk("t1_fault",    {3'b0, fault},    4'd0);
        chk("t1_monState", {2'b0, monState}, 4'd1);

        // 2: conflict
        step(G, G);
        chk("t2_fault",    {3'b0, fault},     4'd1);
        chk("t2_code",     {1'b0, faultCode}, 4'd1);
        chk("t2_road",     {3'b0, faultRoad}, 4'd0);
        chk("t2_flash",    {3'b0, flashReq},  4'd1);
        chk("t2_monState", {2'b0, monState},  4'd2);

        // 5: clear handshake
        step(G, R, 1'b1);
        chk("t5_held_state", {2'b0, monState}, 4'd2);
        chk("t5_held_fault", {3'b0, fault},    4'd1);
        step(R, R, 1'b1);
        chk("t5_init_state", {2'b0, monState},  4'd0);
        chk("t5_init_fault", {3'b0, fault},     4'd0);
        chk("t5_init_code",  {1'b0, faultCode}, 4'd0);
        step(R, R);
        chk("t5_mon_state",  {2'b0, monState},  4'd1);

        // 3: short farm yellow
        step(R, R);
        hold(R, G, 12);
        hold(R, Y, 3);
        step(R, R);
        chk("t3_fault", {3'b0, fault},     4'd1);
        chk("t3_code",  {1'b0, faultCode}, 4'd4);
        chk("t3_road",  {3'b0, faultRoad}, 4'd1);

        // 4: stuck highway yellow, then priority of conflict over illegal encoding
        step(R, R, 1'b1);
        step(R, R);
        step(R, R);
        hold(G, R, 12);
        step(Y, R);
        for (int k = 1; k <= 8; k++) begin
            step(Y, R);
            chk("t4_stuck_fault", {3'b0, fault}, (k == 8) ? 4'd1 : 4'd0);
        end
        chk("t4_stuck_code", {1'b0, faultCode}, 4'd6);
        chk("t4_stuck_road", {3'b0, faultRoad}, 4'd0);
        step(R, R, 1'b1);
        step(R, R);
        step(X, G);
        chk("t4_prio_code", {1'b0, faultCode}, 4'd1);
        chk("t4_prio_road", {3'b0, faultRoad}, 4'd0);

        // 6: reset while faulted, then short all-red gap on farm
        reset_pulse();
        step(G, R);
        hold(G, R, 11);
        hold(Y, R, 5);
        step(R, R);
        step(R, G);
        chk("t6_code", {1'b0, faultCode}, 4'd7);
        chk("t6_road", {3'b0, faultRoad}, 4'd1);

        // Randomized mostly-legal traffic with occasional glitches and clears
        @(negedge Clk);
        reset_pulse();
        hv = G;
        fv = R;
        for (int n = 0; n < 3000; n++) begin
            if (mFault && $urandom_range(3) == 0) begin
                hv = R;
                fv = R;
                step(hv, fv, 1'b1);
            end else begin
                if ($urandom_range(63) == 0)      hv = int'($urandom_range(3));
                else if ($urandom_range(7) == 0)  hv = (hv >= 3) ? R : (hv + 1) % 3;
                if ($urandom_range(63) == 0)      fv = int'($urandom_range(3));
                else if ($urandom_range(7) == 0)  fv = (fv >= 3) ? R : (fv + 1) % 3;
                step(hv, fv, $urandom_range(15) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
